// File: rtl/cactus_spawner.sv
// cactus_spawner
// Spawns up to four cactus obstacles and scrolls them across the screen for the
// dino game. Positions are published through cactuses0..3. While cactus_sync is
// high the consumer must ignore the positions. Spawn gaps are drawn from a
// 16-bit Galois LFSR. The scroll step grows as more cactuses are spawned.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   game_over    1 = freeze everything; a falling edge restarts the game
//   cactuses0..3 slot positions, 0 = empty slot
//   cactus_sync  high for two cycles around every position update
//   step         current per-tick position increment
//   spawn_count  spawns since restart, saturating at 255
module cactus_spawner #(
  parameter int          TICK_DIV      = 500000,
  parameter int          X_SPAWN       = 1,
  parameter int          X_END         = 1224,
  parameter int          STEP_INIT     = 4,
  parameter int          STEP_MAX      = 12,
  parameter int          SPEEDUP_EVERY = 8,
  parameter int          GAP_MIN       = 60,
  parameter int          GAP_MASK      = 63,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          STEP_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_over,
  output logic [11:0]       cactuses0,
  output logic [11:0]       cactuses1,
  output logic [11:0]       cactuses2,
  output logic [11:0]       cactuses3,
  output logic              cactus_sync,
  output logic [STEP_W-1:0] step,
  output logic [7:0]        spawn_count
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = 16;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_TOP  = STEP_W'(STEP_MAX);

  typedef enum logic [2:0] {FROZEN, RUN, PRE, UPD, POST} state_t;

  state_t           state;
  logic             go_prev;
  logic [15:0]      lfsr;
  logic [GAP_W-1:0] gap;
  logic [CNT_W-1:0] tick_cnt;
  logic [11:0]      slot [4];

  logic             restart;
  logic [15:0]      lfsr_next;
  logic [12:0]      sum [4];
  logic [11:0]      new_slot [4];
  logic             found;
  logic [1:0]       spawn_idx;
  logic             spawn;
  logic [7:0]       cnt_inc;
  logic             speedup;
  logic [STEP_W-1:0] step_up;
  logic [GAP_W-1:0] gap_reload;

  assign cactuses0 = slot[0];
  assign cactuses1 = slot[1];
  assign cactuses2 = slot[2];
  assign cactuses3 = slot[3];

  // Next-state values for the LFSR, restart detection and the tick commit.
  always_comb begin
    restart   = go_prev & ~game_over;
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Lowest-index empty slot, judged on the pre-commit positions.
    found     = 1'b0;
    spawn_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (slot[i] == 12'd0)) begin
        found     = 1'b1;
        spawn_idx = 2'(i);
      end else begin
        found     = found;
        spawn_idx = spawn_idx;
      end
    end
    spawn = (gap == '0) && found;

    // Advance occupied slots; anything reaching X_END drops off the screen.
    for (int i = 0; i < 4; i++) begin
      sum[i] = {1'b0, slot[i]} + 13'(step);
      if (spawn && (spawn_idx == 2'(i))) begin
        new_slot[i] = 12'(X_SPAWN);
      end else if (slot[i] == 12'd0) begin
        new_slot[i] = 12'd0;
      end else if (sum[i] >= 13'(X_END)) begin
        new_slot[i] = 12'd0;
      end else begin
        new_slot[i] = sum[i][11:0];
      end
    end

    if (spawn_count == 8'd255) begin
      cnt_inc = 8'd255;
    end else begin
      cnt_inc = spawn_count + 8'd1;
    end

    if (spawn && (cnt_inc != 8'd0) && ((int'(cnt_inc) % SPEEDUP_EVERY) == 0)) begin
      speedup = 1'b1;
    end else begin
      speedup = 1'b0;
    end

    if (step >= STEP_TOP) begin
      step_up = STEP_TOP;
    end else begin
      step_up = step + STEP_W'(1);
    end

    gap_reload = GAP_W'(GAP_MIN) + GAP_W'(lfsr[7:0] & 8'(GAP_MASK));
  end

  // Game state machine: tick timing, sync framing and position commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FROZEN;
      go_prev     <= 1'b1;
      lfsr        <= LFSR_SEED;
      gap         <= GAP_W'(GAP_MIN);
      tick_cnt    <= '0;
      cactus_sync <= 1'b0;
      step        <= STEP_W'(STEP_INIT);
      spawn_count <= 8'd0;
      for (int i = 0; i < 4; i++) slot[i] <= 12'd0;
    end else begin
      lfsr    <= lfsr_next;
      go_prev <= game_over;
      if (restart) begin
        // A falling game_over wins even in the middle of an update sequence.
        state       <= RUN;
        gap         <= GAP_W'(GAP_MIN);
        tick_cnt    <= '0;
        cactus_sync <= 1'b0;
        step        <= STEP_W'(STEP_INIT);
        spawn_count <= 8'd0;
        for (int i = 0; i < 4; i++) slot[i] <= 12'd0;
      end else begin
        case (state)
          FROZEN: begin
            cactus_sync <= 1'b0;
          end
          RUN: begin
            if (game_over) begin
              state <= FROZEN;
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= PRE;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
          PRE: begin
            cactus_sync <= 1'b1;
            state       <= UPD;
          end
          UPD: begin
            for (int i = 0; i < 4; i++) slot[i] <= new_slot[i];
            if (spawn) begin
              gap         <= gap_reload;
              spawn_count <= cnt_inc;
            end else if (gap != '0) begin
              gap <= gap - GAP_W'(1);
            end else begin
              // Every slot busy: hold gap at zero and retry next tick.
              gap <= gap;
            end
            if (speedup) begin
              step <= step_up;
            end else begin
              step <= step;
            end
            state <= POST;
          end
          POST: begin
            cactus_sync <= 1'b0;
            state       <= game_over ? FROZEN : RUN;
          end
          default: begin
            cactus_sync <= 1'b0;
            state       <= FROZEN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cactus_spawner.sv
module tb_cactus_spawner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_over = 1'b1;

  logic [11:0] a_c0, a_c1, a_c2, a_c3;
  logic        a_sync;
  logic [6:0]  a_step;
  logic [7:0]  a_cnt;
  logic [11:0] b_c0, b_c1, b_c2, b_c3;
  logic        b_sync;
  logic [6:0]  b_step;
  logic [7:0]  b_cnt;
  logic [11:0] c_c0, c_c1, c_c2, c_c3;
  logic        c_sync;
  logic [6:0]  c_step;
  logic [7:0]  c_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Main configuration: GAP_MIN=3, STEP_INIT=100.
  cactus_spawner #(.TICK_DIV(4), .X_SPAWN(1), .X_END(1224), .STEP_INIT(100),
    .STEP_MAX(102), .SPEEDUP_EVERY(200), .GAP_MIN(3), .GAP_MASK(0),
    .LFSR_SEED(16'hACE1), .STEP_W(7)) u_a (
    .clk(clk), .rst(rst), .game_over(game_over),
    .cactuses0(a_c0), .cactuses1(a_c1), .cactuses2(a_c2), .cactuses3(a_c3),
    .cactus_sync(a_sync), .step(a_step), .spawn_count(a_cnt));

  // Fill configuration: GAP_MIN=0, STEP_INIT=1.
  cactus_spawner #(.TICK_DIV(4), .X_SPAWN(1), .X_END(1224), .STEP_INIT(1),
    .STEP_MAX(102), .SPEEDUP_EVERY(200), .GAP_MIN(0), .GAP_MASK(0),
    .LFSR_SEED(16'hACE1), .STEP_W(7)) u_b (
    .clk(clk), .rst(rst), .game_over(game_over),
    .cactuses0(b_c0), .cactuses1(b_c1), .cactuses2(b_c2), .cactuses3(b_c3),
    .cactus_sync(b_sync), .step(b_step), .spawn_count(b_cnt));

  // Speed-up configuration: SPEEDUP_EVERY=2, GAP_MIN=0.
  cactus_spawner #(.TICK_DIV(4), .X_SPAWN(1), .X_END(1224), .STEP_INIT(100),
    .STEP_MAX(102), .SPEEDUP_EVERY(2), .GAP_MIN(0), .GAP_MASK(0),
    .LFSR_SEED(16'hACE1), .STEP_W(7)) u_c (
    .clk(clk), .rst(rst), .game_over(game_over),
    .cactuses0(c_c0), .cactuses1(c_c1), .cactuses2(c_c2), .cactuses3(c_c3),
    .cactus_sync(c_sync), .step(c_step), .spawn_count(c_cnt));

  // Reset for two cycles with game_over low; the restart follows on release.
  task automatic do_restart();
    @(negedge clk);
    rst = 1'b1;
    game_over = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for the negedge where cactus_sync is first seen high.
  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (a_sync === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    game_over = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_c0 !== 12'd0 || a_c1 !== 12'd0 || a_c2 !== 12'd0 || a_c3 !== 12'd0) begin
      n_bad++; $display("FAIL reset_slots: got %0d %0d %0d %0d expected 0 0 0 0", a_c0, a_c1, a_c2, a_c3); end
    n_cmp++; if (a_sync !== 1'b0) begin n_bad++; $display("FAIL reset_sync: got %b expected 0", a_sync); end
    n_cmp++; if (a_step !== 7'd100) begin n_bad++; $display("FAIL reset_step: got %0d expected 100", a_step); end
    n_cmp++; if (b_step !== 7'd1) begin n_bad++; $display("FAIL reset_step_b: got %0d expected 1", b_step); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", a_cnt); end
    n_cmp++; if (u_a.lfsr !== 16'hACE1) begin n_bad++; $display("FAIL reset_lfsr: got %h expected ace1", u_a.lfsr); end
    n_cmp++; if (u_a.gap !== 16'd3) begin n_bad++; $display("FAIL reset_gap: got %0d expected 3", u_a.gap); end
    // Release with game_over held: no restart, LFSR keeps shifting.
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (u_a.lfsr !== 16'hE270) begin n_bad++; $display("FAIL lfsr_shift: got %h expected e270", u_a.lfsr); end
    begin
      bit rose = 1'b0;
      repeat (12) begin @(negedge clk); if (a_sync !== 1'b0) rose = 1'b1; end
      n_cmp++; if (rose) begin n_bad++; $display("FAIL frozen_after_reset: got sync high expected low"); end
    end
  endtask

  task automatic test_spawn_scroll();
    bit ok;
    logic [11:0] e0, e1, p0;
    do_restart();
    p0 = 12'd0;
    for (int k = 1; k <= 17; k++) begin
      e0 = (k < 4 || k > 16) ? 12'd0 : 12'(1 + 100 * (k - 4));
      e1 = (k < 8) ? 12'd0 : 12'(1 + 100 * (k - 8));
      wait_rise(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tick_timeout: tick %0d got none expected sync", k); end
      n_cmp++; if (a_c0 !== p0) begin n_bad++; $display("FAIL pre_commit_c0: tick %0d got %0d expected %0d", k, a_c0, p0); end
      @(negedge clk);
      n_cmp++; if (a_sync !== 1'b1) begin n_bad++; $display("FAIL sync_second: tick %0d got %b expected 1", k, a_sync); end
      n_cmp++; if (a_c0 !== e0) begin n_bad++; $display("FAIL scroll_c0: tick %0d got %0d expected %0d", k, a_c0, e0); end
      n_cmp++; if (a_c1 !== e1) begin n_bad++; $display("FAIL scroll_c1: tick %0d got %0d expected %0d", k, a_c1, e1); end
      n_cmp++; if (a_cnt !== 8'(k / 4)) begin n_bad++; $display("FAIL spawn_count: tick %0d got %0d expected %0d", k, a_cnt, k / 4); end
      @(negedge clk);
      n_cmp++; if (a_sync !== 1'b0 || a_c0 !== e0) begin
        n_bad++; $display("FAIL sync_fall: tick %0d got sync %b c0 %0d expected 0 %0d", k, a_sync, a_c0, e0); end
      p0 = e0;
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [11:0] e [4];
    do_restart();
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 4; i++) e[i] = (k > i) ? 12'(k - i) : 12'd0;
      wait_rise(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_timeout: tick %0d got none expected sync", k); end
      @(negedge clk);
      n_cmp++; if (b_c0 !== e[0] || b_c1 !== e[1] || b_c2 !== e[2] || b_c3 !== e[3]) begin
        n_bad++; $display("FAIL fill_slots: tick %0d got %0d %0d %0d %0d expected %0d %0d %0d %0d",
          k, b_c0, b_c1, b_c2, b_c3, e[0], e[1], e[2], e[3]); end
      n_cmp++; if (b_cnt !== 8'((k < 4) ? k : 4)) begin
        n_bad++; $display("FAIL fill_count: tick %0d got %0d expected %0d", k, b_cnt, (k < 4) ? k : 4); end
      @(negedge clk);
    end
    n_cmp++; if (u_b.gap !== 16'd0) begin n_bad++; $display("FAIL full_gap: got %0d expected 0", u_b.gap); end
  endtask

  task automatic test_speedup();
    bit ok;
    int es, ec;
    do_restart();
    for (int k = 1; k <= 16; k++) begin
      es = (k < 2) ? 100 : (k < 4) ? 101 : 102;
      ec = (k <= 4) ? k : (k < 15) ? 4 : k - 10;
      wait_rise(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL speed_timeout: tick %0d got none expected sync", k); end
      @(negedge clk);
      n_cmp++; if (c_step !== 7'(es)) begin n_bad++; $display("FAIL speed_step: tick %0d got %0d expected %0d", k, c_step, es); end
      n_cmp++; if (c_cnt !== 8'(ec)) begin n_bad++; $display("FAIL speed_count: tick %0d got %0d expected %0d", k, c_cnt, ec); end
      @(negedge clk);
    end
  endtask

  task automatic run_ticks(input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_rise(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL run_timeout: tick %0d got none expected sync", k); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    bit moved;
    do_restart();
    run_ticks(4);
    // At the sync-fall negedge the machine is back in RUN.
    game_over = 1'b1;
    moved = 1'b0;
    repeat (30) begin @(negedge clk); if (a_sync !== 1'b0 || a_c0 !== 12'd1) moved = 1'b1; end
    n_cmp++; if (moved) begin n_bad++; $display("FAIL freeze_run: got activity expected frozen (c0 %0d)", a_c0); end
    n_cmp++; if (u_a.gap !== 16'd3 || a_step !== 7'd100 || a_cnt !== 8'd1) begin
      n_bad++; $display("FAIL freeze_state: got gap %0d step %0d cnt %0d expected 3 100 1", u_a.gap, a_step, a_cnt); end
    game_over = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_c0 !== 12'd0 || a_step !== 7'd100 || a_cnt !== 8'd0) begin
      n_bad++; $display("FAIL restart_clear: got c0 %0d step %0d cnt %0d expected 0 100 0", a_c0, a_step, a_cnt); end
    run_ticks(4);
    repeat (4) @(negedge clk);
    // Now in PRE: the update sequence must still complete.
    game_over = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_sync !== 1'b1 || a_c0 !== 12'd1) begin
      n_bad++; $display("FAIL pre_go_first: got sync %b c0 %0d expected 1 1", a_sync, a_c0); end
    @(negedge clk);
    n_cmp++; if (a_sync !== 1'b1 || a_c0 !== 12'd101) begin
      n_bad++; $display("FAIL pre_go_commit: got sync %b c0 %0d expected 1 101", a_sync, a_c0); end
    @(negedge clk);
    n_cmp++; if (a_sync !== 1'b0) begin n_bad++; $display("FAIL pre_go_post: got sync %b expected 0", a_sync); end
    moved = 1'b0;
    repeat (20) begin @(negedge clk); if (a_sync !== 1'b0 || a_c0 !== 12'd101) moved = 1'b1; end
    n_cmp++; if (moved || u_a.gap !== 16'd2) begin
      n_bad++; $display("FAIL pre_go_frozen: got c0 %0d gap %0d expected 101 2 with sync low", a_c0, u_a.gap); end
    game_over = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_c0 !== 12'd0 || a_c1 !== 12'd0 || a_step !== 7'd100 || a_cnt !== 8'd0 || u_a.gap !== 16'd3) begin
      n_bad++; $display("FAIL restart_clear2: got c0 %0d step %0d cnt %0d gap %0d expected 0 100 0 3",
        a_c0, a_step, a_cnt, u_a.gap); end
  endtask

  task automatic test_rst_in_upd();
    bit ok;
    int rise_at;
    do_restart();
    run_ticks(3);
    wait_rise(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL upd_timeout: got none expected sync"); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_c0 !== 12'd0 || a_sync !== 1'b0 || a_cnt !== 8'd0) begin
      n_bad++; $display("FAIL rst_in_upd: got c0 %0d sync %b cnt %0d expected 0 0 0", a_c0, a_sync, a_cnt); end
    rst = 1'b0;
    rise_at = 0;
    for (int j = 1; j <= 12 && rise_at == 0; j++) begin
      @(negedge clk);
      if (a_sync === 1'b1) rise_at = j;
    end
    n_cmp++; if (rise_at != 6) begin n_bad++; $display("FAIL restart_timing: got sync at %0d expected 6", rise_at); end
  endtask

  initial begin
    test_reset();
    test_spawn_scroll();
    test_fill();
    test_speedup();
    test_freeze();
    test_rst_in_upd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
